// File: rtl/clock_failover_pkg.sv
// Shared types and defaults for the clock failover controller.
// The state encoding is visible on the state output, so the values are fixed.
package clock_failover_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    NORMAL   = 2'd0,
    SUSPECT  = 2'd1,
    FAILOVER = 2'd2,
    RECOVER  = 2'd3
  } state_e;

  localparam int DEFAULT_CONFIRM_CNT = 4;
  localparam int DEFAULT_RECOVER_CNT = 16;

  // Sized for the largest legal CONFIRM_CNT (15) and RECOVER_CNT (255).
  localparam int FCNT_W = 4;
  localparam int RCNT_W = 8;

endpackage

// File: rtl/period_tick_gen.sv
// Evaluation strobe generator: one-cycle tick every p cycles, with p = set_period
// (0 treated as 1), and set_period sampled only when the counter reloads.
module period_tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_period,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_eff;
  logic [WIDTH-1:0] base;
  logic             start_q;
  logic             tick_q, tick_d;

  // start_q forces a load on the first edge after reset, so the first tick
  // lands exactly p cycles after release without an async load of set_period.
  // NOTE: every signal written here gets a default-free full assignment, so no latch is inferred.
  always_comb begin
    period_eff = (set_period == '0) ? WIDTH'(1) : set_period;
    base       = (start_q || tick_q) ? period_eff : cnt_q;
    tick_d     = (base == WIDTH'(1));
    cnt_d      = base - WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      start_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clock_failover_ctrl.sv
// Qualifies the clock monitor FAIL flag on periodic ticks and drives the
// backup-clock select, a sticky host alarm and a saturating failover count.
module clock_failover_ctrl
  import clock_failover_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CONFIRM_CNT = DEFAULT_CONFIRM_CNT,
  parameter int RECOVER_CNT = DEFAULT_RECOVER_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fail_in,
  input  logic [WIDTH-1:0]   set_period,
  input  logic               alarm_ack,
  output logic               tick,
  output logic               sel_backup,
  output logic               alarm,
  output logic [STATE_W-1:0] state,
  output logic [WIDTH-1:0]   fail_count
);

  localparam logic [FCNT_W-1:0] CONFIRM_V = FCNT_W'(CONFIRM_CNT);
  localparam logic [RCNT_W-1:0] RECOVER_V = RCNT_W'(RECOVER_CNT);

  logic              sync1_q, fail_s_q;
  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              enter_fo;
  logic              sel_backup_q, sel_backup_d;
  logic              alarm_q, alarm_d;
  logic [WIDTH-1:0]  fail_count_q, fail_count_d;

  period_tick_gen #(
    .WIDTH(WIDTH)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .set_period(set_period),
    .tick      (tick)
  );

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    rcnt_d   = rcnt_q;
    enter_fo = 1'b0;
    if (tick) begin
      unique case (state_q)
        NORMAL: begin
          if (fail_s_q) begin
            if (CONFIRM_V == FCNT_W'(1)) begin
              state_d  = FAILOVER;
              enter_fo = 1'b1;
              fcnt_d   = '0;
            end else begin
              state_d = SUSPECT;
              fcnt_d  = FCNT_W'(1);
            end
          end
        end
        SUSPECT: begin
          if (fail_s_q) begin
            if (fcnt_q + FCNT_W'(1) == CONFIRM_V) begin
              state_d  = FAILOVER;
              enter_fo = 1'b1;
              fcnt_d   = '0;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end else begin
            state_d = NORMAL;
            fcnt_d  = '0;
          end
        end
        FAILOVER: begin
          if (!fail_s_q) begin
            if (RECOVER_V == RCNT_W'(1)) begin
              state_d = NORMAL;
              rcnt_d  = '0;
            end else begin
              state_d = RECOVER;
              rcnt_d  = RCNT_W'(1);
            end
          end
        end
        RECOVER: begin
          if (fail_s_q) begin
            state_d  = FAILOVER;
            enter_fo = 1'b1;
            rcnt_d   = '0;
          end else if (rcnt_q + RCNT_W'(1) == RECOVER_V) begin
            state_d = NORMAL;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: state_d = NORMAL;
      endcase
    end

    sel_backup_d = (state_d == FAILOVER) || (state_d == RECOVER);
    // A new entry outranks a simultaneous host acknowledge.
    alarm_d      = enter_fo ? 1'b1 : (alarm_ack ? 1'b0 : alarm_q);
    fail_count_d = (enter_fo && (fail_count_q != '1)) ? fail_count_q + WIDTH'(1)
                                                      : fail_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      fail_s_q     <= 1'b0;
      state_q      <= NORMAL;
      fcnt_q       <= '0;
      rcnt_q       <= '0;
      sel_backup_q <= 1'b0;
      alarm_q      <= 1'b0;
      fail_count_q <= '0;
    end else begin
      sync1_q      <= fail_in;
      fail_s_q     <= sync1_q;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      rcnt_q       <= rcnt_d;
      sel_backup_q <= sel_backup_d;
      alarm_q      <= alarm_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign sel_backup = sel_backup_q;
  assign alarm      = alarm_q;
  assign state      = state_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_clock_failover_ctrl.sv
// Directed bench for clock_failover_ctrl with default parameters
// (WIDTH=8, CONFIRM_CNT=4, RECOVER_CNT=16).
module tb_clock_failover_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fail_in = 1'b0;
  logic [WIDTH-1:0] set_period = 8'd5;
  logic             alarm_ack = 1'b0;
  logic             tick;
  logic             sel_backup;
  logic             alarm;
  logic [1:0]       state;
  logic [WIDTH-1:0] fail_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  clock_failover_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .fail_in   (fail_in),
    .set_period(set_period),
    .alarm_ack (alarm_ack),
    .tick      (tick),
    .sel_backup(sel_backup),
    .alarm     (alarm),
    .state     (state),
    .fail_count(fail_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until tick is seen; cycles is the number of edges that took.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (tick !== 1'b1 && cycles < 64);
    if (tick !== 1'b1) check("tick_timeout", {31'd0, tick}, 32'd1);
  endtask

  // Wait for a tick, hold alarm_ack during the tick cycle, and stop one
  // cycle later so the evaluation result is visible.
  task automatic eval_tick(input logic ack);
    int c;
    wait_tick(c);
    alarm_ack = ack;
    step(1);
    alarm_ack = 1'b0;
  endtask

  initial begin
    // Reset held with fail_in high.
    rst = 1'b0; fail_in = 1'b1; set_period = 8'd5;
    step(3);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_sel", {31'd0, sel_backup}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_count", {24'd0, fail_count}, 32'd0);

    rst = 1'b1; fail_in = 1'b0;
    wait_tick(n);
    check("first_tick_latency", n, 32'd5);
    check("state_at_first_tick", {30'd0, state}, 32'd0);
    step(1);
    check("state_after_first_eval", {30'd0, state}, 32'd0);

    // Glitch: two failing evaluations, then clean.
    set_period = 8'd4;
    fail_in = 1'b1;
    eval_tick(1'b0);
    check("glitch_suspect1", {30'd0, state}, 32'd1);
    check("glitch_sel1", {31'd0, sel_backup}, 32'd0);
    eval_tick(1'b0);
    check("glitch_suspect2", {30'd0, state}, 32'd1);
    fail_in = 1'b0;
    eval_tick(1'b0);
    check("glitch_normal", {30'd0, state}, 32'd0);
    check("glitch_sel3", {31'd0, sel_backup}, 32'd0);
    check("glitch_count", {24'd0, fail_count}, 32'd0);

    // Confirmed failover on the fourth failing evaluation.
    fail_in = 1'b1;
    eval_tick(1'b0);
    eval_tick(1'b0);
    eval_tick(1'b0);
    check("confirm_state3", {30'd0, state}, 32'd1);
    check("confirm_sel3", {31'd0, sel_backup}, 32'd0);
    eval_tick(1'b0);
    check("confirm_state4", {30'd0, state}, 32'd2);
    check("confirm_sel4", {31'd0, sel_backup}, 32'd1);
    check("confirm_alarm", {31'd0, alarm}, 32'd1);
    check("confirm_count", {24'd0, fail_count}, 32'd1);

    // Recovery interrupted after 10 clean evaluations.
    fail_in = 1'b0;
    eval_tick(1'b0);
    check("recover_state1", {30'd0, state}, 32'd3);
    check("recover_sel1", {31'd0, sel_backup}, 32'd1);
    repeat (9) eval_tick(1'b0);
    check("recover_state10", {30'd0, state}, 32'd3);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    check("ack_clears", {31'd0, alarm}, 32'd0);

    // Relapse with ack on the entry cycle: set must win.
    fail_in = 1'b1;
    eval_tick(1'b1);
    check("relapse_state", {30'd0, state}, 32'd2);
    check("relapse_alarm_set_wins", {31'd0, alarm}, 32'd1);
    check("relapse_count", {24'd0, fail_count}, 32'd2);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    check("late_ack_clears", {31'd0, alarm}, 32'd0);

    // Full recovery: 16 clean evaluations.
    fail_in = 1'b0;
    repeat (15) eval_tick(1'b0);
    check("full_recover15", {30'd0, state}, 32'd3);
    check("full_recover15_sel", {31'd0, sel_backup}, 32'd1);
    eval_tick(1'b0);
    check("full_recover16", {30'd0, state}, 32'd0);
    check("full_recover16_sel", {31'd0, sel_backup}, 32'd0);
    check("full_recover_alarm", {31'd0, alarm}, 32'd0);

    // Period change 4 -> 9 mid-period; we are one cycle after a tick.
    set_period = 8'd9;
    wait_tick(n);
    check("period_old_finishes", n, 32'd3);
    wait_tick(n);
    check("period_new", n, 32'd9);

    // Period 0 behaves as 1: tick every cycle.
    set_period = 8'd0;
    wait_tick(n);
    check("period0_a", n, 32'd1);
    wait_tick(n);
    check("period0_b", n, 32'd1);
    wait_tick(n);
    check("period0_c", n, 32'd1);

    // Saturation: enter failover, then toggle to relapse every two cycles.
    fail_in = 1'b1;
    step(12);
    check("sat_enter_state", {30'd0, state}, 32'd2);
    check("sat_enter_count", {24'd0, fail_count}, 32'd3);
    for (int i = 0; i < 600; i++) begin
      fail_in = ~fail_in;
      step(1);
    end
    check("sat_count", {24'd0, fail_count}, 32'd255);
    check("sat_tick_live", {31'd0, tick}, 32'd1);

    // Asynchronous reset in the middle of a cycle.
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    check("async_rst_state", {30'd0, state}, 32'd0);
    check("async_rst_sel", {31'd0, sel_backup}, 32'd0);
    check("async_rst_alarm", {31'd0, alarm}, 32'd0);
    check("async_rst_count", {24'd0, fail_count}, 32'd0);
    #10;
    rst = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_failover_ctrl.md
# clock_failover_ctrl

Downstream consumer of the ring-oscillator clock monitor. It takes the monitor's raw FAIL flag and its clamped SET_PERIOD. It synchronises and qualifies FAIL on a periodic evaluation tick, then drives the backup-clock select. It also raises a sticky, acknowledgeable alarm toward the host and keeps a saturating count of failover events.

## Interface
Parameters:
- WIDTH, 8, width of set_period and fail_count
- CONFIRM_CNT, 4, consecutive failing evaluations needed to declare failover (legal 1..15)
- RECOVER_CNT, 16, consecutive passing evaluations needed to leave failover (legal 1..255)

Ports:
- clk  input  1  single system clock, all logic on posedge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- fail_in  input  1  monitor FAIL flag, asynchronous to clk
- set_period  input  WIDTH  evaluation period in clk cycles, from monitor SET_PERIOD
- alarm_ack  input  1  host clears alarm, level, sampled each cycle
- tick  output  1  one-cycle evaluation strobe
- sel_backup  output  1  1 = system must run from backup clock
- alarm  output  1  sticky failover alarm
- state  output  2  current FSM state
- fail_count  output  WIDTH  saturating number of FAILOVER entries

## Operation
- **Synchroniser:** fail_in passes through two flops, producing fail_s. Reset value is 0.
- **Tick generator:**
  - Uses a WIDTH-bit down counter. Effective period p = set_period, with 0 treated as 1.
  - tick is high for exactly one cycle every p cycles.
  - set_period is sampled only at reload, i.e. the cycle tick is high. A change mid-period takes effect from the next period.
- **Evaluation:** all FSM transitions happen only on cycles with tick=1, using fail_s.
- **FSM encoding:** NORMAL=0, SUSPECT=1, FAILOVER=2, RECOVER=3.
  - NORMAL:
    - fail_s=1 → SUSPECT, fcnt=1.
    - If CONFIRM_CNT==1, fail_s=1 goes directly to FAILOVER.
  - SUSPECT:
    - fail_s=1 → fcnt+1. When fcnt+1 == CONFIRM_CNT → FAILOVER.
    - fail_s=0 → NORMAL, fcnt=0.
  - FAILOVER:
    - fail_s=1 → stay.
    - fail_s=0 → RECOVER, rcnt=1. If RECOVER_CNT==1, go directly to NORMAL.
  - RECOVER:
    - fail_s=0 → rcnt+1. When rcnt+1 == RECOVER_CNT → NORMAL, rcnt=0.
    - fail_s=1 → FAILOVER, rcnt=0.
- **sel_backup:** registered. It is 1 in FAILOVER and RECOVER, and 0 in NORMAL and SUSPECT.
- **alarm:**
  - Set on every entry into FAILOVER, whether from NORMAL, SUSPECT or RECOVER.
  - Cleared on a cycle where alarm_ack=1 and no entry occurs.
  - If set and ack happen on the same cycle, set wins.
- **fail_count:** +1 on every FAILOVER entry. It saturates at 2^WIDTH−1 and never wraps.
- **Mid-operation reset:** asserting rst returns every register to its reset value immediately, independent of clk.

## Timing
- Reset values:
  - tick=0, sel_backup=0, alarm=0, state=NORMAL, fail_count=0.
  - fcnt=0, rcnt=0, synchroniser=0.
  - Tick counter loaded so the first tick occurs p cycles after rst deasserts.
- fail_in to fail_s latency is 2 clk edges. Pulses on fail_in shorter than one clk period may be missed; this is acceptable.
- From a tick where the FSM enters FAILOVER, state, sel_backup, alarm and fail_count all update on that same clk edge. They are visible the following cycle.
- Worst-case detection latency is 2 + CONFIRM_CNT·p cycles. Worst-case recovery latency is 2 + RECOVER_CNT·p cycles.
- Outside tick cycles, fail_s is ignored. The FSM, fcnt and rcnt hold.

## Structure
- Package clock_failover_pkg holds:
  - the state localparams (NORMAL/SUSPECT/FAILOVER/RECOVER) and the 2-bit state width;
  - default CONFIRM_CNT/RECOVER_CNT.
- One sub-module, period_tick_gen:
  - down counter with set_period load and 0→1 clamp;
  - outputs tick;
  - ports clk, rst, set_period, tick.
- Synchroniser, FSM, alarm and counter stay in the top module.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with fail_in=1, set_period=5. Outputs hold reset values. After release, the first tick comes 5 cycles later and the FSM stays NORMAL until fail_s is seen on a tick.
- **Confirmed failover:** set_period=4, CONFIRM_CNT=4, fail_in=1 steady.
  - Expected: NORMAL→SUSPECT→…→FAILOVER on the 4th tick.
  - After that: sel_backup=1, alarm=1, fail_count=1.
- **Glitch rejection:** fail_in=1 for 2 ticks, then 0.
  - Expected: SUSPECT then back to NORMAL; sel_backup never 1; fail_count=0.
- **Recovery and relapse:** from FAILOVER with RECOVER_CNT=16, set fail_in=0 for 10 ticks, then 1.
  - Expected: back to FAILOVER, alarm re-set, fail_count=2.
  - Then hold 0 for 16 ticks. Expected: NORMAL, sel_backup=0.
- **Alarm handshake:** pulse alarm_ack on the same cycle as a FAILOVER entry. Expected: alarm stays 1. A later ack clears it to 0.
- **Period change and saturation:**
  - Change set_period 4→9 mid-period. Expected: the current period still ends at 4, the next period is 9.
  - set_period=0 gives tick every cycle.
  - Force 260 failover entries with WIDTH=8. Expected: fail_count=255.
